// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: parses command frames from the byte stream, drives the ALU
// and returns the 2*DATA_WIDTH-bit result as two bytes, low byte first.
module alu_cmd_sequencer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CMD_OPR    = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_NOOPR  = 8'hDD,
    parameter int                    TIMEOUT    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [3:0]              alu_fun,
    output logic                    alu_en,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_out_valid,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_busy,
    output logic                    busy,
    output logic                    frame_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, SEND_LO, SEND_HI} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]              fun_q, fun_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (rx_valid) begin
                if (rx_data == CMD_OPR) state_d = GET_A;
                else if (rx_data == CMD_NOOPR) state_d = GET_FUN;
                else err_d = 1'b1;
            end
            GET_A: if (rx_valid) begin
                a_d     = rx_data;
                state_d = GET_B;
            end
            GET_B: if (rx_valid) begin
                b_d     = rx_data;
                state_d = GET_FUN;
            end
            GET_FUN: if (rx_valid) begin
                fun_d   = rx_data[3:0];
                state_d = EXEC;
            end
            EXEC: begin
                err_d   = rx_valid;
                cnt_d   = '0;
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                err_d = rx_valid;
                if (alu_out_valid) begin
                    res_d   = alu_out;
                    state_d = SEND_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            SEND_LO: begin
                err_d   = rx_valid;
                state_d = tx_busy ? SEND_LO : SEND_HI;
            end
            SEND_HI: begin
                err_d   = rx_valid;
                state_d = tx_busy ? SEND_HI : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_fun   = fun_q;
    assign alu_en    = state_q == EXEC;
    assign tx_valid  = state_q == SEND_LO || state_q == SEND_HI;
    assign tx_data   = state_q == SEND_HI ? res_q[2*DATA_WIDTH-1:DATA_WIDTH] : res_q[DATA_WIDTH-1:0];
    assign busy      = state_q != IDLE;
    assign frame_err = err_q;
endmodule
